// File: rtl/scrambler.sv
// scrambler: 802.11a x^7+x^4+1 data scrambler on an AXI4-Stream with a one-entry skid buffer.
module scrambler #(
  parameter int WIDTH = 24,
  parameter int USER_WIDTH = 4,
  parameter logic [6:0] DEFAULT_SEED = 7'h7F
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [6:0]            cfg_seed,
  input  logic [WIDTH-1:0]      s_axis_tdata,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [WIDTH-1:0]      m_axis_tdata,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);
  logic [6:0] lfsr, start, next_lfsr;
  logic sof, ready, acc, drain, skid_valid, skid_last, out_valid, out_last;
  logic [WIDTH-1:0] scr, skid_data, out_data;
  logic [USER_WIDTH-1:0] skid_user, out_user;
  assign s_axis_tready = ready;
  assign m_axis_tdata = out_data;
  assign m_axis_tuser = out_user;
  assign m_axis_tlast = out_last;
  assign m_axis_tvalid = out_valid;
  assign acc = s_axis_tvalid & ready;
  assign drain = ~out_valid | m_axis_tready;
  assign start = sof ? (cfg_seed == 7'd0 ? DEFAULT_SEED : cfg_seed) : lfsr;
  always_comb begin
    next_lfsr = start;
    scr = s_axis_tdata;
    for (int i = 0; i < WIDTH; i++) begin
      scr[i] = s_axis_tdata[i] ^ next_lfsr[6] ^ next_lfsr[3];
      next_lfsr = {next_lfsr[5:0], next_lfsr[6] ^ next_lfsr[3]};
    end
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      lfsr <= '0;
      sof <= 1'b1;
      ready <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_user <= '0;
      out_last <= 1'b0;
      skid_valid <= 1'b0;
      skid_data <= '0;
      skid_user <= '0;
      skid_last <= 1'b0;
    end else begin
      if (acc) begin
        lfsr <= next_lfsr;
        sof <= s_axis_tlast;
      end
      if (drain) begin
        out_valid <= skid_valid | acc;
        if (skid_valid)
          {out_data, out_user, out_last} <= {skid_data, skid_user, skid_last};
        else if (acc)
          {out_data, out_user, out_last} <= {scr, s_axis_tuser, s_axis_tlast};
        skid_valid <= 1'b0;
      end else if (acc) begin
        skid_valid <= 1'b1;
        {skid_data, skid_user, skid_last} <= {scr, s_axis_tuser, s_axis_tlast};
      end
      ready <= drain | (~acc & ~skid_valid);
    end
  end
endmodule

// File: tb/tb_scrambler.sv
// tb_scrambler: directed-vector bench for the 802.11a scrambler with hand-computed outputs.
module tb_scrambler;
  localparam logic [3:0] RATE_9M = 4'hF;
  logic aclk, areset, s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [6:0] cfg_seed;
  logic [23:0] s_axis_tdata, m_axis_tdata;
  logic [3:0] s_axis_tuser, m_axis_tuser;
  int vectors = 0;
  int miscompares = 0;

  scrambler dut (
    .aclk(aclk), .areset(areset), .cfg_seed(cfg_seed),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic [23:0] d, input logic [3:0] u, input logic l);
    s_axis_tdata = d;
    s_axis_tuser = u;
    s_axis_tlast = l;
    s_axis_tvalid = 1'b1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick();
    tick();
    vectors++;
    if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready: got %b want 0", s_axis_tready); end
    vectors++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 24'h0 || m_axis_tuser !== 4'h0 || m_axis_tlast !== 1'b0) begin
      miscompares++; $display("FAIL reset_out: got v=%b d=%h u=%h l=%b want all 0", m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast);
    end
    areset = 1'b0;
    tick();
    vectors++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      miscompares++; $display("FAIL post_reset: got rdy=%b v=%b want 1 0", s_axis_tready, m_axis_tvalid);
    end
  endtask

  task automatic run_two_beat(input logic [6:0] seed, input string tag);
    cfg_seed = seed;
    drive(24'h0, 4'h0, 1'b0);
    vectors++;
    if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL %s_ready: got %b want 1", tag, s_axis_tready); end
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'h934F70 || m_axis_tlast !== 1'b0) begin
      miscompares++; $display("FAIL %s_beat0: got v=%b d=%h l=%b want 1 934f70 0", tag, m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    drive(24'h0, 4'h0, 1'b1);
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'h746440 || m_axis_tlast !== 1'b1) begin
      miscompares++; $display("FAIL %s_beat1: got v=%b d=%h l=%b want 1 746440 1", tag, m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    s_axis_tvalid = 1'b0;
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL %s_idle: got v=%b want 0", tag, m_axis_tvalid); end
  endtask

  task automatic test_seed_7f();
    run_two_beat(7'h7F, "seed7f");
  endtask

  task automatic test_default_seed();
    run_two_beat(7'h00, "seed0");
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_d [4] = '{24'h934F70, 24'h746440, 24'h934F70, 24'h746440};
    cfg_seed = 7'h7F;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) cfg_seed = 7'h55;
      drive(24'h0, 4'h0, i[0]);
      tick();
      vectors++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d[i] || m_axis_tlast !== i[0]) begin
        miscompares++; $display("FAIL b2b_beat%0d: got v=%b d=%h l=%b want 1 %h %b", i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_d[i], i[0]);
      end
    end
    s_axis_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    cfg_seed = 7'h7F;
    m_axis_tready = 1'b0;
    drive(24'h0, 4'h0, 1'b0);
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'h934F70 || s_axis_tready !== 1'b1) begin
      miscompares++; $display("FAIL bp_first: got v=%b d=%h rdy=%b want 1 934f70 1", m_axis_tvalid, m_axis_tdata, s_axis_tready);
    end
    drive(24'h0, 4'h0, 1'b1);
    tick();
    vectors++;
    if (s_axis_tready !== 1'b0 || m_axis_tdata !== 24'h934F70 || m_axis_tvalid !== 1'b1) begin
      miscompares++; $display("FAIL bp_skid: got rdy=%b v=%b d=%h want 0 1 934f70", s_axis_tready, m_axis_tvalid, m_axis_tdata);
    end
    drive(24'h0, 4'h0, 1'b1);
    tick();
    vectors++;
    if (s_axis_tready !== 1'b0 || m_axis_tdata !== 24'h934F70 || m_axis_tlast !== 1'b0) begin
      miscompares++; $display("FAIL bp_hold: got rdy=%b d=%h l=%b want 0 934f70 0", s_axis_tready, m_axis_tdata, m_axis_tlast);
    end
    m_axis_tready = 1'b1;
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'h746440 || m_axis_tlast !== 1'b1 || s_axis_tready !== 1'b1) begin
      miscompares++; $display("FAIL bp_drain: got v=%b d=%h l=%b rdy=%b want 1 746440 1 1", m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready);
    end
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'h934F70 || m_axis_tlast !== 1'b1) begin
      miscompares++; $display("FAIL bp_resume: got v=%b d=%h l=%b want 1 934f70 1", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    s_axis_tvalid = 1'b0;
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL bp_empty: got v=%b want 0", m_axis_tvalid); end
  endtask

  task automatic test_descramble();
    cfg_seed = 7'h7F;
    drive(24'h000C8D, 4'h0, 1'b1);
    tick();
    vectors++;
    if (m_axis_tdata !== 24'h9343FD) begin miscompares++; $display("FAIL descr_fwd: got %h want 9343fd", m_axis_tdata); end
    drive(24'h9343FD, 4'h0, 1'b1);
    tick();
    vectors++;
    if (m_axis_tdata !== 24'h000C8D) begin miscompares++; $display("FAIL descr_back: got %h want 000c8d", m_axis_tdata); end
    s_axis_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    cfg_seed = 7'h7F;
    drive(24'h0, RATE_9M, 1'b1);
    tick();
    vectors++;
    if (m_axis_tuser !== RATE_9M || m_axis_tdata !== 24'h934F70 || m_axis_tlast !== 1'b1) begin
      miscompares++; $display("FAIL tuser_pass: got u=%h d=%h l=%b want f 934f70 1", m_axis_tuser, m_axis_tdata, m_axis_tlast);
    end
    s_axis_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midframe();
    cfg_seed = 7'h7F;
    m_axis_tready = 1'b0;
    drive(24'h0, 4'h0, 1'b0);
    tick();
    drive(24'h0, 4'h0, 1'b0);
    tick();
    vectors++;
    if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL mid_skid: got rdy=%b want 0", s_axis_tready); end
    s_axis_tvalid = 1'b0;
    areset = 1'b1;
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset: got v=%b rdy=%b want 0 0", m_axis_tvalid, s_axis_tready);
    end
    areset = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    drive(24'h0, 4'h0, 1'b1);
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'h934F70) begin
      miscompares++; $display("FAIL mid_reseed: got v=%b d=%h want 1 934f70", m_axis_tvalid, m_axis_tdata);
    end
    s_axis_tvalid = 1'b0;
    tick();
  endtask

  initial begin
    cfg_seed = 7'h7F;
    s_axis_tdata = '0;
    s_axis_tuser = '0;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    areset = 1'b1;
    #1;
    test_reset();
    test_seed_7f();
    test_default_seed();
    test_back_to_back();
    test_backpressure();
    test_descramble();
    test_passthrough();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
